pc_gen: RTL and testbench

Parametrised next-generation program-counter unit for the pipelined core.
- Generates fetch addresses through a valid/ready handshake with the instruction-fetch port.
- Supports 2- or 4-byte sequential stepping (optional C extension) and pipeline stall.
- Accepts prioritised control-flow redirects (trap over branch/jump).
- Buffers a redirect that arrives while a fetch request is outstanding, so the request address never changes before acceptance.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_target_sel.sv | 29 ++
 rtl/pc_gen.sv | 119 +++++++++++
 tb/tb_pc_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program-counter unit
package pc_pkg;

    // Natural address width of the core; pend_t stores addresses at this width.
    localparam int PC_AW   = 32;
    localparam int STEP_32 = 4;
    localparam int STEP_16 = 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } pc_state_e;

    // Redirect captured while a fetch request is outstanding.
    typedef struct packed {
        logic             valid;
        logic             trap;
        logic [PC_AW-1:0] addr;
    } pend_t;

endpackage

// File: rtl/pc_target_sel.sv
// rtl/pc_target_sel.sv - trap/redirect target mux with alignment fix-up
module pc_target_sel
    import pc_pkg::*;
#(
    parameter int AW    = PC_AW,
    parameter bit C_EXT = 1'b0
) (
    input  logic          i_trap,
    input  logic [AW-1:0] i_redirect_pc,
    input  logic [AW-1:0] i_trap_vec,
    output logic [AW-1:0] o_target,
    output logic          o_misalign
);

    logic [AW-1:0] w_raw;

    // Trap wins over branch/jump; bit 0 is never a valid fetch address bit,
    // and without compressed support bit 1 is cleared and flagged.
    always_comb begin
        w_raw      = i_trap ? i_trap_vec : i_redirect_pc;
        o_target   = w_raw;
        o_target[0] = 1'b0;
        o_misalign = !C_EXT && w_raw[1];
        if (o_misalign) begin
            o_target[1] = 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-address generator with handshake, stall and redirect buffering
`ifndef PC_RST_ADDR
`define PC_RST_ADDR 32'h8000_0000
`endif

module pc_gen
    import pc_pkg::*;
#(
    parameter int            AW       = PC_AW,
    parameter logic [AW-1:0] RST_ADDR = AW'(`PC_RST_ADDR),
    parameter bit            C_EXT    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          trap,
    input  logic [AW-1:0] trap_vec,
    input  logic          is_compressed,
    output logic          fetch_valid,
    input  logic          fetch_ready,
    output logic [AW-1:0] fetch_addr,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_next,
    output logic          discard,
    output logic          misalign
);

    pc_state_e     r_state;
    pc_state_e     w_state_next;
    logic [AW-1:0] r_pc;
    pend_t         r_pend;
    logic          r_pend_mis;
    logic          r_misalign;

    logic          w_fire;
    logic          w_redir;
    logic [AW-1:0] w_target;
    logic          w_target_mis;
    logic [AW-1:0] w_step;

    pc_target_sel #(
        .AW    (AW),
        .C_EXT (C_EXT)
    ) u_target_sel (
        .i_trap        (trap),
        .i_redirect_pc (redirect_pc),
        .i_trap_vec    (trap_vec),
        .o_target      (w_target),
        .o_misalign    (w_target_mis)
    );

    assign fetch_valid = (r_state == REQ);
    assign w_fire      = fetch_valid & fetch_ready;
    assign w_redir     = trap | redirect;
    assign w_step      = (C_EXT && is_compressed) ? AW'(STEP_16) : AW'(STEP_32);
    assign pc_next     = r_pc + w_step;
    assign pc          = r_pc;
    assign fetch_addr  = r_pc;
    // A buffered redirect means the request being accepted now is on the wrong path.
    assign discard     = w_fire & r_pend.valid;
    assign misalign    = r_misalign;

    // Next-state logic: one idle BOOT cycle, then request/wait under stall control.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = stall ? WAIT : REQ;
            REQ:     if (w_fire) w_state_next = stall ? WAIT : REQ;
            WAIT:    if (!stall) w_state_next = REQ;
            default: w_state_next = BOOT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC register and pending-redirect buffer; the address only moves when no
    // request is outstanding or when the outstanding request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RST_ADDR;
            r_pend     <= '0;
            r_pend_mis <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (w_redir && (r_state != REQ || w_fire)) begin
                r_pc       <= w_target;
                r_pend     <= '0;
                r_pend_mis <= 1'b0;
                r_misalign <= w_target_mis;
            end else if (w_redir) begin
                // A pending trap is never displaced by a plain branch/jump.
                if (trap || !r_pend.valid || !r_pend.trap) begin
                    r_pend.valid <= 1'b1;
                    r_pend.trap  <= trap;
                    r_pend.addr  <= PC_AW'(w_target);
                    r_pend_mis   <= w_target_mis;
                end
            end else if (w_fire && r_pend.valid) begin
                r_pc       <= AW'(r_pend.addr);
                r_pend     <= '0;
                r_pend_mis <= 1'b0;
                r_misalign <= r_pend_mis;
            end else if (w_fire) begin
                r_pc <= pc_next;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard testbench for pc_gen (C_EXT=0 and C_EXT=1 instances)
module tb_pc_gen;

    typedef struct {
        logic [31:0] addr;
        logic        disc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap;
    logic [31:0] trap_vec;
    logic        is_compressed;
    logic        fetch_ready;

    logic        fv0, dc0, mis0;
    logic [31:0] fa0, pc0, pn0;
    logic        fv1, dc1, mis1;
    logic [31:0] fa1, pc1, pn1;

    exp_t q0[$];
    exp_t q1[$];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pc_gen #(.AW(32), .RST_ADDR(32'h8000_0000), .C_EXT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .trap(trap), .trap_vec(trap_vec),
        .is_compressed(is_compressed), .fetch_valid(fv0), .fetch_ready(fetch_ready),
        .fetch_addr(fa0), .pc(pc0), .pc_next(pn0), .discard(dc0), .misalign(mis0)
    );

    pc_gen #(.AW(32), .RST_ADDR(32'h8000_0000), .C_EXT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .trap(trap), .trap_vec(trap_vec),
        .is_compressed(is_compressed), .fetch_valid(fv1), .fetch_ready(fetch_ready),
        .fetch_addr(fa1), .pc(pc1), .pc_next(pn1), .discard(dc1), .misalign(mis1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic push_both(input logic [31:0] a0, input logic [31:0] a1, input logic d);
        exp_t e;
        e.addr = a0; e.disc = d; q0.push_back(e);
        e.addr = a1; q1.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset, then redirect during the BOOT cycle so REQ starts at address a.
    task automatic start_at(input logic [31:0] a);
        fetch_ready = 1'b0;
        stall       = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        redirect = 1'b1;
        redirect_pc = a;
        cyc(1);
        redirect = 1'b0;
    endtask

    // Monitor for the C_EXT=0 instance: every accepted fetch must match the next expectation.
    always @(negedge clk) begin
        if (fv0 && fetch_ready) begin
            if (q0.size() == 0) begin
                n_total++;
                $display("FAIL dut0 unexpected fire: addr 0x%08h, no expectation queued", fa0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0 fetch_addr", fa0, e.addr);
                check("dut0 discard", {31'b0, dc0}, {31'b0, e.disc});
            end
        end
    end

    // Monitor for the C_EXT=1 instance.
    always @(negedge clk) begin
        if (fv1 && fetch_ready) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL dut1 unexpected fire: addr 0x%08h, no expectation queued", fa1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1 fetch_addr", fa1, e.addr);
                check("dut1 discard", {31'b0, dc1}, {31'b0, e.disc});
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        trap = 1'b0; trap_vec = '0; is_compressed = 1'b0; fetch_ready = 1'b1;

        // Reset state and sequential stepping from RST_ADDR.
        cyc(2);
        check("reset fetch_valid", {31'b0, fv0}, 32'd0);
        check("reset pc", pc0, 32'h8000_0000);
        check("reset discard", {31'b0, dc0}, 32'd0);
        check("reset misalign", {31'b0, mis0}, 32'd0);
        rst = 1'b0;
        push_both(32'h8000_0000, 32'h8000_0000, 1'b0);
        push_both(32'h8000_0004, 32'h8000_0004, 1'b0);
        push_both(32'h8000_0008, 32'h8000_0008, 1'b0);
        #2;
        check("boot fetch_valid dut0", {31'b0, fv0}, 32'd0);
        check("boot fetch_valid dut1", {31'b0, fv1}, 32'd0);
        cyc(4);
        fetch_ready = 1'b0;

        // Compressed stepping on dut1, fixed 4-byte stepping on dut0.
        start_at(32'h100);
        push_both(32'h100, 32'h100, 1'b0);
        push_both(32'h104, 32'h102, 1'b0);
        push_both(32'h108, 32'h106, 1'b0);
        push_both(32'h10C, 32'h108, 1'b0);
        fetch_ready = 1'b1; is_compressed = 1'b1; cyc(1);
        is_compressed = 1'b0; cyc(1);
        is_compressed = 1'b1; cyc(1);
        is_compressed = 1'b0; cyc(1);
        fetch_ready = 1'b0;

        // Redirect while request outstanding: address held, discard on fire.
        start_at(32'h200);
        redirect = 1'b1; redirect_pc = 32'h400; cyc(1);
        redirect = 1'b0;
        check("held addr c1", fa0, 32'h200);
        check("held valid c1", {31'b0, fv0}, 32'd1);
        cyc(1);
        check("held addr c2", fa0, 32'h200);
        push_both(32'h200, 32'h200, 1'b1);
        push_both(32'h400, 32'h400, 1'b0);
        fetch_ready = 1'b1; cyc(2);
        fetch_ready = 1'b0;

        // Trap then redirect: pending trap is kept.
        start_at(32'h200);
        trap = 1'b1; trap_vec = 32'h1000; cyc(1);
        trap = 1'b0; redirect = 1'b1; redirect_pc = 32'h400; cyc(1);
        redirect = 1'b0;
        push_both(32'h200, 32'h200, 1'b1);
        push_both(32'h1000, 32'h1000, 1'b0);
        fetch_ready = 1'b1; cyc(2);
        fetch_ready = 1'b0;

        // Redirect then trap: trap overwrites the pending redirect.
        start_at(32'h200);
        redirect = 1'b1; redirect_pc = 32'h400; cyc(1);
        redirect = 1'b0; trap = 1'b1; trap_vec = 32'h1000; cyc(1);
        trap = 1'b0;
        push_both(32'h200, 32'h200, 1'b1);
        push_both(32'h1000, 32'h1000, 1'b0);
        fetch_ready = 1'b1; cyc(2);
        fetch_ready = 1'b0;

        // Stall over a fire, redirect to a half-word target during WAIT.
        start_at(32'h300);
        push_both(32'h300, 32'h300, 1'b0);
        stall = 1'b1; fetch_ready = 1'b1; cyc(1);
        check("stall valid c1", {31'b0, fv0}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h502; cyc(1);
        redirect = 1'b0;
        check("stall valid c2", {31'b0, fv0}, 32'd0);
        check("misalign dut0 pulse", {31'b0, mis0}, 32'd1);
        check("misalign dut1 none", {31'b0, mis1}, 32'd0);
        check("wait redirect pc dut0", pc0, 32'h500);
        check("wait redirect pc dut1", pc1, 32'h502);
        cyc(1);
        stall = 1'b0;
        check("stall valid c3", {31'b0, fv0}, 32'd0);
        check("misalign one cycle", {31'b0, mis0}, 32'd0);
        push_both(32'h500, 32'h502, 1'b0);
        cyc(2);
        fetch_ready = 1'b0;

        // Address wrap-around.
        start_at(32'hFFFF_FFFC);
        check("wrap pc_next", pn0, 32'h0000_0000);
        push_both(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        push_both(32'h0000_0000, 32'h0000_0000, 1'b0);
        fetch_ready = 1'b1; cyc(2);
        fetch_ready = 1'b0;

        // Reset mid-transaction with a redirect pending.
        start_at(32'h600);
        redirect = 1'b1; redirect_pc = 32'h700; cyc(1);
        redirect = 1'b0;
        check("pre-reset valid", {31'b0, fv0}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async reset valid dut0", {31'b0, fv0}, 32'd0);
        check("async reset pc dut0", pc0, 32'h8000_0000);
        check("async reset valid dut1", {31'b0, fv1}, 32'd0);
        check("async reset pc dut1", pc1, 32'h8000_0000);
        cyc(1);
        rst = 1'b0;
        fetch_ready = 1'b1;
        push_both(32'h8000_0000, 32'h8000_0000, 1'b0);
        push_both(32'h8000_0004, 32'h8000_0004, 1'b0);
        cyc(3);
        fetch_ready = 1'b0;

        cyc(2);
        check("q0 drained", q0.size(), 32'd0);
        check("q1 drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
